// File: rtl/conf_int_mac_pipe.sv
// conf_int_mac_pipe: pipelined unsigned multiply-accumulate with runtime
// precision masking, an accurate-product bypass, a saturating accumulator with
// sticky overflow, and valid/ready handshakes on both sides.
module conf_int_mac_pipe #(
    parameter int DATA_PATH_BITWIDTH = 16,
    parameter int ACC_BITWIDTH       = 48,
    parameter int PIPE_STAGES        = 2,
    parameter int PREC_W             = $clog2(DATA_PATH_BITWIDTH + 1)
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            in_valid,
    output logic                            in_ready,
    input  logic [DATA_PATH_BITWIDTH-1:0]   a,
    input  logic [DATA_PATH_BITWIDTH-1:0]   b,
    input  logic [PREC_W-1:0]               prec,
    input  logic                            acc_en,
    input  logic                            acc__sel,
    input  logic [2*DATA_PATH_BITWIDTH-1:0] d__acc,
    output logic                            out_valid,
    input  logic                            out_ready,
    output logic [ACC_BITWIDTH-1:0]         d,
    output logic                            ovf
);

    localparam int DW   = DATA_PATH_BITWIDTH;
    localparam int PW   = 2 * DATA_PATH_BITWIDTH;
    localparam int LAST = PIPE_STAGES - 1;

    if (ACC_BITWIDTH < 2 * DATA_PATH_BITWIDTH || PIPE_STAGES < 1 || PIPE_STAGES > 4) begin : g_param_check
        $error("conf_int_mac_pipe: illegal parameter combination");
    end

    logic                    advance;
    logic [DW-1:0]           keep_mask;
    logic [DW-1:0]           a_masked;
    logic [DW-1:0]           b_masked;
    logic [PW-1:0]           prod_in;
    logic [PW-1:0]           pipe_prod   [PIPE_STAGES];
    logic                    pipe_valid  [PIPE_STAGES];
    logic                    pipe_acc_en [PIPE_STAGES];
    logic [ACC_BITWIDTH:0]   sum_ext;
    logic                    sum_sat;

    // One global advance: the whole pipe moves only when the output slot frees up.
    assign advance  = !out_valid || out_ready;
    assign in_ready = advance;

    // Bit i survives when it lies within the top prec bits; prec=0 clears all,
    // prec >= DW keeps all.
    always_comb begin
        keep_mask = '0;
        for (int i = 0; i < DW; i++) begin
            keep_mask[i] = (int'(prec) >= DW - i);
        end
    end

    assign a_masked = a & keep_mask;
    assign b_masked = b & keep_mask;
    assign prod_in  = acc__sel ? d__acc : (PW'(a_masked) * PW'(b_masked));

    // Product shift register; bubbles enter with valid=0 and everything holds on stall.
    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int i = 0; i < PIPE_STAGES; i++) begin
                pipe_valid[i]  <= 1'b0;
                pipe_prod[i]   <= '0;
                pipe_acc_en[i] <= 1'b0;
            end
        end else if (advance) begin
            pipe_valid[0]  <= in_valid;
            pipe_prod[0]   <= prod_in;
            pipe_acc_en[0] <= acc_en;
            for (int i = 1; i < PIPE_STAGES; i++) begin
                pipe_valid[i]  <= pipe_valid[i-1];
                pipe_prod[i]   <= pipe_prod[i-1];
                pipe_acc_en[i] <= pipe_acc_en[i-1];
            end
        end
    end

    // One extra bit on the sum catches any carry out of the accumulator width.
    assign sum_ext = {1'b0, d} + (ACC_BITWIDTH + 1)'(pipe_prod[LAST]);
    assign sum_sat = sum_ext[ACC_BITWIDTH];

    // Accumulator stage: load or add, saturate on carry-out, ovf is sticky across adds.
    always_ff @(posedge clk) begin
        if (!rst) begin
            out_valid <= 1'b0;
            d         <= '0;
            ovf       <= 1'b0;
        end else if (advance) begin
            out_valid <= pipe_valid[LAST];
            if (pipe_valid[LAST]) begin
                if (!pipe_acc_en[LAST]) begin
                    d   <= ACC_BITWIDTH'(pipe_prod[LAST]);
                    ovf <= 1'b0;
                end else if (sum_sat) begin
                    d   <= '1;
                    ovf <= 1'b1;
                end else begin
                    d   <= sum_ext[ACC_BITWIDTH-1:0];
                end
            end
        end
    end

endmodule

// File: tb/tb_conf_int_mac_pipe.sv
// tb_conf_int_mac_pipe: directed scenarios plus a randomized stream checked
// against an arithmetic reference model of the multiply-accumulate.
module tb_conf_int_mac_pipe;

    localparam int W    = 16;
    localparam int ACCW = 33;
    localparam int PS   = 2;
    localparam int PW   = $clog2(W + 1);

    logic            clk = 1'b0;
    logic            rst = 1'b0;
    logic            in_valid = 1'b0;
    logic            in_ready;
    logic [W-1:0]    a = '0;
    logic [W-1:0]    b = '0;
    logic [PW-1:0]   prec = '0;
    logic            acc_en = 1'b0;
    logic            acc__sel = 1'b0;
    logic [2*W-1:0]  d__acc = '0;
    logic            out_valid;
    logic            out_ready = 1'b1;
    logic [ACCW-1:0] d;
    logic            ovf;

    typedef struct {
        logic [W-1:0]   a;
        logic [W-1:0]   b;
        int             prec;
        bit             acc_en;
        bit             sel;
        logic [2*W-1:0] dacc;
    } beat_t;

    beat_t             pend[$];
    logic [ACCW-1:0]   got_d[$];
    bit                got_o[$];
    longint unsigned   mdl_acc = 0;
    bit                mdl_ovf = 0;
    int                n_pass  = 0;
    int                n_total = 0;

    conf_int_mac_pipe #(
        .DATA_PATH_BITWIDTH(W),
        .ACC_BITWIDTH(ACCW),
        .PIPE_STAGES(PS)
    ) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .prec(prec),
        .acc_en(acc_en), .acc__sel(acc__sel), .d__acc(d__acc),
        .out_valid(out_valid), .out_ready(out_ready),
        .d(d), .ovf(ovf)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    function automatic beat_t mk(input int av, input int bv, input int p,
                                 input bit ae, input bit sl, input logic [2*W-1:0] da);
        beat_t r;
        r.a = av[W-1:0];
        r.b = bv[W-1:0];
        r.prec = p;
        r.acc_en = ae;
        r.sel = sl;
        r.dacc = da;
        return r;
    endfunction

    function automatic beat_t rand_beat(input bit first);
        beat_t r;
        r.a      = W'($urandom);
        r.b      = W'($urandom);
        r.prec   = ($urandom_range(0, 3) == 0) ? 16 : $urandom_range(0, 20);
        r.acc_en = first ? 1'b0 : ($urandom_range(0, 1) == 1);
        r.sel    = ($urandom_range(0, 7) == 0);
        r.dacc   = $urandom;
        return r;
    endfunction

    // Keep the top p bits of a W-bit operand using plain division.
    function automatic longint unsigned keep_top(input longint unsigned v, input int p);
        longint unsigned step;
        if (p >= W) return v;
        step = 64'd1 << (W - p);
        return (v / step) * step;
    endfunction

    // Reference result for the oldest outstanding beat.
    function automatic void model_next(output longint unsigned exp_d, output bit exp_ovf);
        beat_t bt;
        longint unsigned prod, sum, maxv;
        bt   = pend.pop_front();
        maxv = (64'd1 << ACCW) - 1;
        prod = bt.sel ? longint'(bt.dacc) : keep_top(bt.a, bt.prec) * keep_top(bt.b, bt.prec);
        if (!bt.acc_en) begin
            mdl_acc = prod;
            mdl_ovf = 0;
        end else begin
            sum = mdl_acc + prod;
            if (sum > maxv) begin
                mdl_acc = maxv;
                mdl_ovf = 1;
            end else begin
                mdl_acc = sum;
            end
        end
        exp_d   = mdl_acc;
        exp_ovf = mdl_ovf;
    endfunction

    // One clock: drive at the falling edge, sample 1 ns later, then cross the rising edge.
    task automatic cycle(input bit v, input beat_t bt, input bit ordy,
                         output bit ir, output bit accepted, output bit fired,
                         output logic [ACCW-1:0] od, output bit oo);
        in_valid  = v;
        a         = bt.a;
        b         = bt.b;
        prec      = PW'(bt.prec);
        acc_en    = bt.acc_en;
        acc__sel  = bt.sel;
        d__acc    = bt.dacc;
        out_ready = ordy;
        #1;
        ir       = in_ready;
        accepted = v && in_ready;
        fired    = out_valid && out_ready;
        od       = d;
        oo       = ovf;
        @(posedge clk);
        @(negedge clk);
    endtask

    // Stream a list of beats with out_ready held high and gather the results.
    task automatic run_beats(input beat_t bs[$], input int budget, output int n_cyc);
        int i;
        bit ir, acc, fired, oo;
        logic [ACCW-1:0] od;
        beat_t idle;
        idle = mk(0, 0, 0, 0, 0, 0);
        i = 0;
        n_cyc = 0;
        got_d.delete();
        got_o.delete();
        while (n_cyc < budget && (i < bs.size() || got_d.size() < bs.size())) begin
            if (i < bs.size()) cycle(1'b1, bs[i], 1'b1, ir, acc, fired, od, oo);
            else               cycle(1'b0, idle,  1'b1, ir, acc, fired, od, oo);
            n_cyc++;
            if (acc) i++;
            if (fired) begin
                got_d.push_back(od);
                got_o.push_back(oo);
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        #1;
        n_total++;
        if (out_valid !== 1'b0) $display("[TB] FAIL reset_out_valid got=%b exp=0", out_valid); else n_pass++;
        n_total++;
        if (in_ready !== 1'b1) $display("[TB] FAIL reset_in_ready got=%b exp=1", in_ready); else n_pass++;
        n_total++;
        if (d !== '0 || ovf !== 1'b0) $display("[TB] FAIL reset_d_ovf got d=%h ovf=%b exp 0/0", d, ovf); else n_pass++;
    endtask

    task automatic test_full_precision();
        bit ir, acc, fired, oo;
        logic [ACCW-1:0] od;
        beat_t idle;
        idle = mk(0, 0, 0, 0, 0, 0);
        cycle(1'b1, mk(3, 5, 16, 0, 0, 0), 1'b1, ir, acc, fired, od, oo);
        n_total++;
        if (acc !== 1'b1) $display("[TB] FAIL fullprec_accept got=%b exp=1", acc); else n_pass++;
        for (int k = 1; k <= PS + 1; k++) begin
            cycle(1'b0, idle, 1'b1, ir, acc, fired, od, oo);
            n_total++;
            if (fired !== (k == PS + 1))
                $display("[TB] FAIL fullprec_latency cycle=%0d got out_valid=%b exp=%b", k, fired, (k == PS + 1));
            else n_pass++;
        end
        n_total++;
        if (od !== 33'd15 || oo !== 1'b0) $display("[TB] FAIL fullprec_value got d=%0d ovf=%b exp 15/0", od, oo); else n_pass++;
    endtask

    task automatic test_reduced_precision();
        beat_t bs[$];
        int n;
        logic [ACCW-1:0] exp_v [4] = '{33'h0012_0000, 33'h0, 33'h4000_0000, 33'h0013_11FF};
        bs.push_back(mk('h12FF, 'h0101, 8, 0, 0, 0));
        bs.push_back(mk('hFFFF, 'hFFFF, 0, 0, 0, 0));
        bs.push_back(mk('hFFFF, 'hFFFF, 1, 0, 0, 0));
        bs.push_back(mk('h12FF, 'h0101, 20, 0, 0, 0));
        run_beats(bs, 40, n);
        n_total++;
        if (got_d.size() != 4) $display("[TB] FAIL prec_count got=%0d exp=4", got_d.size()); else n_pass++;
        if (got_d.size() == 4) begin
            for (int k = 0; k < 4; k++) begin
                n_total++;
                if (got_d[k] !== exp_v[k]) $display("[TB] FAIL prec_value idx=%0d got=%h exp=%h", k, got_d[k], exp_v[k]);
                else n_pass++;
            end
        end
    endtask

    task automatic test_saturation();
        beat_t bs[$];
        int n;
        logic [ACCW-1:0] exp_v [4] = '{33'h0_FFFE_0001, 33'h1_FFFC_0002, 33'h1_FFFF_FFFF, 33'h1};
        bit exp_o [4] = '{1'b0, 1'b0, 1'b1, 1'b0};
        bs.push_back(mk('hFFFF, 'hFFFF, 16, 0, 0, 0));
        bs.push_back(mk('hFFFF, 'hFFFF, 16, 1, 0, 0));
        bs.push_back(mk('hFFFF, 'hFFFF, 16, 1, 0, 0));
        bs.push_back(mk(1, 1, 16, 0, 0, 0));
        run_beats(bs, 40, n);
        n_total++;
        if (got_d.size() != 4) $display("[TB] FAIL sat_count got=%0d exp=4", got_d.size()); else n_pass++;
        if (got_d.size() == 4) begin
            for (int k = 0; k < 4; k++) begin
                n_total++;
                if (got_d[k] !== exp_v[k] || got_o[k] !== exp_o[k])
                    $display("[TB] FAIL sat_value idx=%0d got d=%h ovf=%b exp d=%h ovf=%b", k, got_d[k], got_o[k], exp_v[k], exp_o[k]);
                else n_pass++;
            end
        end
    endtask

    task automatic test_bypass();
        beat_t bs[$];
        int n;
        bs.push_back(mk('hFFFF, 'hFFFF, 16, 0, 1, 32'h0000_ABCD));
        bs.push_back(mk(2, 3, 16, 1, 0, 32'hDEAD_BEEF));
        run_beats(bs, 40, n);
        n_total++;
        if (got_d.size() != 2) $display("[TB] FAIL bypass_count got=%0d exp=2", got_d.size()); else n_pass++;
        if (got_d.size() == 2) begin
            n_total++;
            if (got_d[0] !== 33'hABCD) $display("[TB] FAIL bypass_value got=%h exp=abcd", got_d[0]); else n_pass++;
            n_total++;
            if (got_d[1] !== 33'hABD3) $display("[TB] FAIL bypass_then_add got=%h exp=abd3", got_d[1]); else n_pass++;
        end
    endtask

    task automatic test_back_to_back();
        beat_t bs[$];
        int n;
        longint unsigned e;
        for (int i = 0; i < 10; i++) bs.push_back(mk(i + 1, 2, 16, i != 0, 0, 0));
        run_beats(bs, 60, n);
        n_total++;
        if (n != 10 + PS + 1) $display("[TB] FAIL b2b_cycles got=%0d exp=%0d", n, 10 + PS + 1); else n_pass++;
        n_total++;
        if (got_d.size() != 10) $display("[TB] FAIL b2b_count got=%0d exp=10", got_d.size()); else n_pass++;
        if (got_d.size() == 10) begin
            for (int k = 0; k < 10; k++) begin
                e = longint'((k + 1) * (k + 2));
                n_total++;
                if (got_d[k] !== e[ACCW-1:0]) $display("[TB] FAIL b2b_value idx=%0d got=%0d exp=%0d", k, got_d[k], e);
                else n_pass++;
            end
        end
    endtask

    task automatic test_backpressure();
        int issued, stall;
        bit v, ordy, ir, acc, fired, oo;
        logic [ACCW-1:0] od;
        beat_t bt;
        issued = 0;
        stall  = 0;
        got_d.delete();
        for (int c = 0; c < 60 && got_d.size() < 8; c++) begin
            v    = (issued < 8);
            bt   = mk(issued, 1, 16, 0, 0, 0);
            ordy = !(out_valid && stall < 5);
            cycle(v, bt, ordy, ir, acc, fired, od, oo);
            if (!ordy) begin
                stall++;
                n_total++;
                if (ir !== 1'b0) $display("[TB] FAIL bp_in_ready stall=%0d got=%b exp=0", stall, ir); else n_pass++;
                n_total++;
                if (od !== '0) $display("[TB] FAIL bp_d_hold stall=%0d got=%0d exp=0", stall, od); else n_pass++;
            end
            if (acc) issued++;
            if (fired) got_d.push_back(od);
        end
        n_total++;
        if (stall != 5 || got_d.size() != 8)
            $display("[TB] FAIL bp_count got stalls=%0d outputs=%0d exp 5/8", stall, got_d.size());
        else n_pass++;
        if (got_d.size() == 8) begin
            for (int k = 0; k < 8; k++) begin
                n_total++;
                if (got_d[k] !== ACCW'(k)) $display("[TB] FAIL bp_order idx=%0d got=%0d exp=%0d", k, got_d[k], k);
                else n_pass++;
            end
        end
    endtask

    task automatic test_reset_midstream();
        bit ir, acc, fired, oo;
        logic [ACCW-1:0] od;
        beat_t idle;
        beat_t bs[$];
        int n, spurious;
        idle = mk(0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 3; i++) cycle(1'b1, mk(7 + i, 9, 16, 0, 0, 0), 1'b1, ir, acc, fired, od, oo);
        in_valid = 1'b0;
        rst = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        #1;
        n_total++;
        if (out_valid !== 1'b0 || d !== '0 || ovf !== 1'b0 || in_ready !== 1'b1)
            $display("[TB] FAIL midrst_state got ov=%b d=%0d ovf=%b ir=%b exp 0/0/0/1", out_valid, d, ovf, in_ready);
        else n_pass++;
        @(negedge clk);
        spurious = 0;
        for (int c = 0; c < 8; c++) begin
            cycle(1'b0, idle, 1'b1, ir, acc, fired, od, oo);
            if (fired) spurious++;
        end
        n_total++;
        if (spurious != 0) $display("[TB] FAIL midrst_leak got=%0d exp=0", spurious); else n_pass++;
        bs.push_back(mk(4, 5, 16, 1, 0, 0));
        run_beats(bs, 20, n);
        n_total++;
        if (got_d.size() != 1 || got_d[0] !== 33'd20)
            $display("[TB] FAIL midrst_first_add got n=%0d d=%0d exp 1/20", got_d.size(), (got_d.size() > 0) ? got_d[0] : '0);
        else n_pass++;
    endtask

    task automatic test_random();
        int issued;
        bit v, ordy, ir, acc, fired, oo, eo;
        logic [ACCW-1:0] od;
        longint unsigned ed;
        beat_t bt;
        issued = 0;
        pend.delete();
        bt = rand_beat(1'b1);
        for (int c = 0; c < 4000 && (issued < 200 || pend.size() > 0); c++) begin
            v    = (issued < 200) && ($urandom_range(0, 9) < 8);
            ordy = ($urandom_range(0, 3) != 0);
            cycle(v, bt, ordy, ir, acc, fired, od, oo);
            if (fired) begin
                n_total++;
                if (pend.size() == 0) begin
                    $display("[TB] FAIL rand_spurious got d=%h with no beat outstanding", od);
                end else begin
                    model_next(ed, eo);
                    if (od !== ed[ACCW-1:0] || oo !== eo)
                        $display("[TB] FAIL rand_value got d=%h ovf=%b exp d=%h ovf=%b", od, oo, ed[ACCW-1:0], eo);
                    else n_pass++;
                end
            end
            if (acc) begin
                pend.push_back(bt);
                issued++;
                bt = rand_beat(1'b0);
            end
        end
        n_total++;
        if (issued != 200 || pend.size() != 0)
            $display("[TB] FAIL rand_drain got issued=%0d outstanding=%0d exp 200/0", issued, pend.size());
        else n_pass++;
    endtask

    initial begin
        test_reset();
        test_full_precision();
        test_reduced_precision();
        test_saturation();
        test_bypass();
        test_back_to_back();
        test_backpressure();
        test_reset_midstream();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/conf_int_mac_pipe.md
Name: conf_int_mac_pipe

Overview:
- Pipelined, configurable-precision unsigned integer multiply-accumulate. Next generation of the team's flop-less configurable multiplier wrapper.
- Adds runtime precision selection by operand LSB masking, a parametrised product pipeline, an accumulator with saturation and sticky overflow, and valid/ready handshakes on both sides.
- Keeps the accurate-result bypass: d__acc replaces the approximate product when acc__sel is high.
- Sits between the operand-fetch stage and the result buffer of the duplicated-PE datapath.

Parameters:
- DATA_PATH_BITWIDTH, 16, operand width; product width is 2*DATA_PATH_BITWIDTH.
- ACC_BITWIDTH, 48, accumulator and output width; must be >= 2*DATA_PATH_BITWIDTH.
- PIPE_STAGES, 2, number of product register stages; legal range 1..4.
- PREC_W, $clog2(DATA_PATH_BITWIDTH+1), width of the prec port.

Ports:
- clk  input  1  clock; all logic on the rising edge.
- rst  input  1  reset; synchronous, active-low.
- in_valid  input  1  input beat valid.
- in_ready  output  1  block accepts a beat when in_valid && in_ready.
- a  input  DATA_PATH_BITWIDTH  operand A, unsigned.
- b  input  DATA_PATH_BITWIDTH  operand B, unsigned.
- prec  input  PREC_W  number of MSBs kept per operand; sampled with the beat.
- acc_en  input  1  0 = load the product, 1 = add the product to the accumulator; sampled with the beat.
- acc__sel  input  1  1 = use d__acc in place of the approximate product; sampled with the beat.
- d__acc  input  2*DATA_PATH_BITWIDTH  externally computed accurate product; sampled with the beat.
- out_valid  output  1  result valid.
- out_ready  input  1  downstream accepts when out_valid && out_ready.
- d  output  ACC_BITWIDTH  accumulator value.
- ovf  output  1  sticky saturation flag, valid alongside d.

Behaviour:
- Reset:
  - rst low at a clock edge clears all stage valid bits, the accumulator, d and ovf to 0.
  - out_valid is 0 and in_ready is 1 the cycle after reset.
  - Beats in flight when reset is asserted are discarded; there is no partial output.
- Handshake:
  - in_ready = !out_valid || out_ready; this signal is also the global advance.
  - On advance, every stage shifts one step and bubbles carry valid = 0.
  - When advance is low, all stages hold.
  - No beat is lost or duplicated, and beats stay in order.
  - d and ovf are stable while out_valid && !out_ready.
- Latency: PIPE_STAGES+1 cycles from an accepted beat to out_valid, with no stalls. Throughput is 1 beat per cycle.
- Precision masking (stage 0):
  - Keep the top min(prec, DATA_PATH_BITWIDTH) bits of a and of b, and zero the remaining LSBs.
  - prec = 0 gives a product of 0; prec >= DATA_PATH_BITWIDTH gives the full-precision product.
- Product:
  - Unsigned, 2*DATA_PATH_BITWIDTH bits, no truncation.
  - If acc__sel is 1, the masked product is replaced by d__acc.
  - The product is registered PIPE_STAGES times; acc_en travels with the beat.
- Accumulator stage:
  - acc_en = 0: acc = zero-extended product; ovf = 0.
  - acc_en = 1: compute the sum at ACC_BITWIDTH+1 bits.
    - If it exceeds 2^ACC_BITWIDTH-1: acc saturates to all-ones and ovf = 1.
    - Otherwise acc = sum and ovf keeps its value (sticky).
  - d is the accumulator register; out_valid is its valid bit.
- Simultaneous acceptance and output, with a full pipeline and out_ready = 1: both happen in the same cycle, giving full throughput.
- acc_en = 1 on the first beat after reset: adds to 0.

Test Plan:
- Full-precision multiply:
  - Stimulus: DATA_PATH_BITWIDTH=16, PIPE_STAGES=2; prec=16, a=3, b=5, acc_en=0, accepted at cycle T.
  - Required: out_valid=1 and d=15 at cycle T+3, ovf=0.
- Reduced precision:
  - Stimulus: prec=8, a=0x12FF, b=0x0101, acc_en=0.
  - Required: d=0x0012_0000 (masked operands 0x1200 × 0x0100). With prec=0 on any operands: d=0.
- Saturation:
  - Stimulus: ACC_BITWIDTH=33; a=b=0xFFFF, prec=16; acc_en sequence 0, 1, 1.
  - Required: d=0xFFFE0001, then 0x1FFFC0002, then 0x1FFFFFFFF with ovf=1.
  - A following beat with acc_en=0, a=b=1 must give d=1, ovf=0.
- Accurate bypass:
  - Stimulus: acc__sel=1, d__acc=0x0000ABCD, a=b=0xFFFF, acc_en=0.
  - Required: d=0xABCD.
- Backpressure:
  - Stimulus: 8 back-to-back beats a=i, b=1, acc_en=0; hold out_ready=0 for 5 cycles once the first result appears.
  - Required: in_ready=0 while stalled, d holds, and the outputs 0..7 arrive in order with no loss or duplication.
- Reset mid-stream:
  - Stimulus: drive rst=0 for one edge with 3 beats in flight.
  - Required: next cycle out_valid=0, d=0, ovf=0, in_ready=1; none of the in-flight results appear afterwards.
